// File: rtl/hx711_emu.sv
// HX711 load-cell ADC emulator: device side of the PD_SCK/DOUT link, serving 24-bit
// samples from an internal source with data-ready, gain select by pulse count and power-down.
module hx711_emu #(
  parameter int DATA_W      = 24,
  parameter int CONV_CYCLES = 5_000_000,
  parameter int PD_TIMEOUT  = 3000,
  parameter int TAIL_GAP    = 256
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              pd_sck,
  output logic              dout,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [1:0]        gain_sel,
  output logic              conv_done,
  output logic              pwr_down,
  output logic [2:0]        dbg_state
);

  localparam int CW    = $clog2(CONV_CYCLES + 1);
  localparam int TW    = $clog2(PD_TIMEOUT + 1);
  localparam int GW    = $clog2(TAIL_GAP + 1);
  localparam int CNT_W = $clog2(DATA_W + 4);

  localparam logic [CW-1:0]    CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [TW-1:0]    PD_LAST   = TW'(PD_TIMEOUT - 1);
  localparam logic [TW-1:0]    PD_SAT    = TW'(PD_TIMEOUT);
  localparam logic [GW-1:0]    GAP_LAST  = GW'(TAIL_GAP - 1);
  localparam logic [GW-1:0]    GAP_SAT   = GW'(TAIL_GAP);
  localparam logic [CNT_W-1:0] CNT_DATA  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_BASE  = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DATA_W + 3);

  typedef enum logic [2:0] {
    S_CONV  = 3'd0,
    S_WAIT  = 3'd1,
    S_READY = 3'd2,
    S_SHIFT = 3'd3,
    S_TAIL  = 3'd4,
    S_PDOWN = 3'd5
  } state_t;

  state_t            state, state_n;
  logic              sck_m, sck_s, sck_q;
  logic              sck_rise, sck_fall;
  logic [TW-1:0]     hi_cnt;
  logic [GW-1:0]     lo_cnt;
  logic              pd_hit, gap_hit;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic              hold_take;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CNT_W-1:0]  gain_diff;
  logic [CW-1:0]     conv_cnt, conv_cnt_n;
  logic              dout_n, conv_done_n;
  logic [1:0]        gain_n;

  // Two-flop synchronizer plus one delay stage; dout therefore moves on the third
  // clk_50 edge after pd_sck rises at the pin.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      sck_m <= 1'b0;
      sck_s <= 1'b0;
      sck_q <= 1'b0;
    end else begin
      sck_m <= pd_sck;
      sck_s <= sck_m;
      sck_q <= sck_s;
    end
  end

  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;

  // High-time and low-time counters saturate so long idle periods stay stable.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      if (!sck_s)                hi_cnt <= '0;
      else if (hi_cnt != PD_SAT) hi_cnt <= hi_cnt + 1'b1;
      if (sck_s)                 lo_cnt <= '0;
      else if (lo_cnt != GAP_SAT) lo_cnt <= lo_cnt + 1'b1;
    end
  end

  assign pd_hit  = sck_s && (hi_cnt == PD_LAST);
  assign gap_hit = !sck_s && (lo_cnt >= GAP_LAST);

  // Sample handshake: a word moves into the holding register on a cycle where
  // sample_valid and sample_ready are both high; sample_ready is simply "holding empty",
  // and the register empties only when its word is copied into the shift register.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (hold_take) begin
      hold_full <= 1'b0;
    end else if (sample_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= sample_data;
    end
  end

  assign sample_ready = ~hold_full;
  assign gain_diff    = cnt - CNT_BASE;

  always_comb begin
    state_n     = state;
    dout_n      = dout;
    shift_n     = shift_q;
    cnt_n       = cnt;
    conv_cnt_n  = conv_cnt;
    gain_n      = gain_sel;
    conv_done_n = 1'b0;
    hold_take   = 1'b0;
    case (state)
      S_CONV: begin
        dout_n = 1'b1;
        if (conv_cnt == CONV_LAST) begin
          conv_cnt_n = '0;
          state_n    = S_WAIT;
        end else begin
          conv_cnt_n = conv_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        dout_n = 1'b1;
        if (hold_full) begin
          shift_n     = hold_data;
          hold_take   = 1'b1;
          conv_done_n = 1'b1;
          dout_n      = 1'b0;
          state_n     = S_READY;
        end
      end
      S_READY: begin
        dout_n = 1'b0;
        if (sck_rise) begin
          dout_n  = shift_q[DATA_W-1];
          shift_n = {shift_q[DATA_W-2:0], 1'b0};
          cnt_n   = CNT_W'(1);
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (sck_rise) begin
          cnt_n = cnt + 1'b1;
          if (cnt < CNT_DATA) begin
            dout_n  = shift_q[DATA_W-1];
            shift_n = {shift_q[DATA_W-2:0], 1'b0};
          end else begin
            dout_n  = 1'b1;
            state_n = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        dout_n = 1'b1;
        if (cnt == CNT_MAX || gap_hit) begin
          gain_n     = gain_diff[1:0];
          cnt_n      = '0;
          conv_cnt_n = '0;
          state_n    = S_CONV;
        end else if (sck_rise) begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_PDOWN: begin
        dout_n = 1'b1;
        if (sck_fall) begin
          gain_n     = 2'd0;
          cnt_n      = '0;
          conv_cnt_n = '0;
          state_n    = S_CONV;
        end
      end
      default: begin
        dout_n  = 1'b1;
        state_n = S_CONV;
      end
    endcase
    // Power-down wins over any readout in progress; the holding register survives.
    if (pd_hit && state != S_PDOWN) begin
      state_n     = S_PDOWN;
      dout_n      = 1'b1;
      shift_n     = '0;
      cnt_n       = '0;
      conv_done_n = 1'b0;
      hold_take   = 1'b0;
    end
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state     <= S_CONV;
      dout      <= 1'b1;
      shift_q   <= '0;
      cnt       <= '0;
      conv_cnt  <= '0;
      gain_sel  <= 2'd0;
      conv_done <= 1'b0;
    end else begin
      state     <= state_n;
      dout      <= dout_n;
      shift_q   <= shift_n;
      cnt       <= cnt_n;
      conv_cnt  <= conv_cnt_n;
      gain_sel  <= gain_n;
      conv_done <= conv_done_n;
    end
  end

  assign pwr_down  = (state == S_PDOWN);
  assign dbg_state = state;

endmodule

// File: tb/tb_hx711_emu.sv
// Directed bench for hx711_emu: emulates the weight-ADC reader and checks each
// captured word against an expected queue, plus gain, power-down and reset corners.
module tb_hx711_emu;

  localparam int DW   = 24;
  localparam int CONV = 40;
  localparam int PDT  = 3000;
  localparam int GAP  = 256;
  localparam int HALF = 32;

  logic          clk_50 = 1'b0;
  logic          rst;
  logic          pd_sck;
  logic          dout;
  logic [DW-1:0] sample_data;
  logic          sample_valid;
  logic          sample_ready;
  logic [1:0]    gain_sel;
  logic          conv_done;
  logic          pwr_down;
  logic [2:0]    dbg_state;

  hx711_emu #(
    .DATA_W(DW), .CONV_CYCLES(CONV), .PD_TIMEOUT(PDT), .TAIL_GAP(GAP)
  ) dut (
    .clk_50(clk_50), .rst(rst), .pd_sck(pd_sck), .dout(dout),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .gain_sel(gain_sel), .conv_done(conv_done), .pwr_down(pwr_down), .dbg_state(dbg_state)
  );

  always #10 clk_50 = ~clk_50;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    int         pulses;
    logic [DW-1:0] data;
    logic [1:0] gain;
  } vec_t;
  vec_t vecs[6];

  always @(negedge clk_50) if (!rst && conv_done) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [DW-1:0] d);
    int n;
    n = 0;
    @(negedge clk_50);
    sample_valid = 1'b1;
    sample_data  = d;
    while (!sample_ready && n < 4000) begin
      @(negedge clk_50);
      n++;
    end
    check("load_ready", {31'd0, sample_ready}, 32'd1);
    @(negedge clk_50);
    sample_valid = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (dout !== 1'b0 && n < CONV + 400) begin
      @(negedge clk_50);
      n++;
    end
    check(name, {31'd0, dout}, 32'd0);
  endtask

  // Reader side: sample dout late in each high phase, MSB first.
  task automatic read(input int pulses, input bit lat, input logic lat_bit,
                      output logic [DW-1:0] v);
    v = '0;
    for (int i = 0; i < pulses; i++) begin
      pd_sck = 1'b1;
      repeat (2) @(negedge clk_50);
      if (lat && i == 0) check("lat_2cyc", {31'd0, dout}, 32'd0);
      @(negedge clk_50);
      if (lat && i == 0) check("lat_3cyc", {31'd0, dout}, {31'd0, lat_bit});
      repeat (HALF - 3) @(negedge clk_50);
      if (i < DW) v = {v[DW-2:0], dout};
      else check("dout_tail", {31'd0, dout}, 32'd1);
      pd_sck = 1'b0;
      repeat (HALF) @(negedge clk_50);
    end
  endtask

  task automatic read_check(input string name, input int pulses);
    logic [DW-1:0] v, e;
    read(pulses, 1'b0, 1'b0, v);
    e = exp_q.pop_front();
    check(name, {8'd0, v}, {8'd0, e});
  endtask

  initial begin
    logic [DW-1:0] v, e;
    int n;
    vecs[0] = '{25, 24'hA5A5A5, 2'd0};
    vecs[1] = '{27, 24'h800001, 2'd2};
    vecs[2] = '{26, 24'h123456, 2'd1};
    vecs[3] = '{25, 24'h7FFFFF, 2'd0};
    vecs[4] = '{27, 24'hFFFFFF, 2'd2};
    vecs[5] = '{26, 24'h5A0F3C, 2'd1};

    // Reset values
    rst = 1'b1; pd_sck = 1'b0; sample_valid = 1'b0; sample_data = '0;
    repeat (3) @(negedge clk_50);
    check("rst_dout", {31'd0, dout}, 32'd1);
    check("rst_ready", {31'd0, sample_ready}, 32'd1);
    check("rst_gain", {30'd0, gain_sel}, 32'd0);
    check("rst_conv_done", {31'd0, conv_done}, 32'd0);
    check("rst_pwr_down", {31'd0, pwr_down}, 32'd0);

    // First conversion: ready drops, dout low after CONV+1 cycles with conv_done
    rst = 1'b0;
    sample_valid = 1'b1;
    sample_data  = 24'hA5A5A5;
    exp_q.push_back(24'hA5A5A5);
    n = 0;
    do begin
      @(negedge clk_50);
      n++;
      if (n == 1) begin
        sample_valid = 1'b0;
        check("ready_after_load", {31'd0, sample_ready}, 32'd0);
      end
    end while (dout !== 1'b0 && n < CONV + 100);
    check("first_ready_cycles", n, CONV + 1);
    check("conv_done_pulse", {31'd0, conv_done}, 32'd1);
    @(negedge clk_50);
    check("conv_done_single", {31'd0, conv_done}, 32'd0);

    // Table: pulse count selects gain, data captured MSB first
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        load(vecs[i].data);
        wait_ready($sformatf("ready_v%0d", i));
      end
      read(vecs[i].pulses, i == 0, vecs[i].data[DW-1], v);
      e = exp_q.pop_front();
      check($sformatf("data_v%0d", i), {8'd0, v}, {8'd0, e});
      repeat (GAP + 20) @(negedge clk_50);
      check($sformatf("gain_v%0d", i), {30'd0, gain_sel}, {30'd0, vecs[i].gain});
    end

    // Power-down mid-SHIFT (gain is 1 from the last vector)
    load(24'h654321);
    wait_ready("ready_pd");
    read(10, 1'b0, 1'b0, v);
    void'(exp_q.pop_front());
    pd_sck = 1'b1;
    repeat (PDT - 10) @(negedge clk_50);
    check("pd_not_early", {31'd0, pwr_down}, 32'd0);
    repeat (20) @(negedge clk_50);
    check("pd_entered", {31'd0, pwr_down}, 32'd1);
    check("pd_dout", {31'd0, dout}, 32'd1);
    check("pd_gain_kept", {30'd0, gain_sel}, 32'd1);
    pd_sck = 1'b0;
    repeat (10) @(negedge clk_50);
    check("pd_exit", {31'd0, pwr_down}, 32'd0);
    check("pd_gain_clr", {30'd0, gain_sel}, 32'd0);
    load(24'h13579B);
    wait_ready("ready_after_pd");
    read_check("data_after_pd", 25);
    repeat (GAP + 20) @(negedge clk_50);

    // New sample during readout is held until the next conversion
    load(24'h3C3C3C);
    wait_ready("ready_hold_a");
    load(24'hC0FFEE);
    check("hold_ready_low", {31'd0, sample_ready}, 32'd0);
    read_check("data_hold_a", 25);
    repeat (GAP + 20) @(negedge clk_50);
    wait_ready("ready_hold_b");
    check("hold_ready_back", {31'd0, sample_ready}, 32'd1);
    read_check("data_hold_b", 25);
    repeat (GAP + 20) @(negedge clk_50);

    // Reset at bit 12 of a readout
    load(24'h0F0F0F);
    wait_ready("ready_rst");
    read(12, 1'b0, 1'b0, v);
    void'(exp_q.pop_front());
    check("pre_rst_dout", {31'd0, dout}, 32'd0);
    rst = 1'b1;
    #1;
    check("rst_async_dout", {31'd0, dout}, 32'd1);
    repeat (3) @(negedge clk_50);
    rst = 1'b0;
    load(24'h2468AC);
    wait_ready("ready_after_rst");
    read_check("data_after_rst", 25);
    repeat (GAP + 20) @(negedge clk_50);
    check("gain_after_rst", {30'd0, gain_sel}, 32'd0);

    check("conv_done_count", done_cnt, 12);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
